// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: compacts masked fetch groups into a
// circular buffer and presents up to DEC_W in-order instructions per cycle.
module inst_queue #(
   parameter int FETCH_W = 4,
   parameter int DEC_W   = 4,
   parameter int DEPTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [32*FETCH_W-1:0]     in_inst,
   input  logic [FETCH_W-1:0]        in_mask,
   input  logic [31:0]               in_pc,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [32*DEC_W-1:0]       out_inst,
   output logic [32*DEC_W-1:0]       out_pc,
   output logic [DEC_W-1:0]          out_mask,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - FETCH_W);
   localparam logic [CNT_W-1:0] DEC_N     = CNT_W'(DEC_W);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [31:0]      mem_inst [DEPTH];
   logic [31:0]      mem_pc   [DEPTH];

   logic [CNT_W-1:0] slot_off [FETCH_W];
   logic [CNT_W-1:0] enq_num;
   logic [CNT_W-1:0] out_num;
   logic             enq_fire;
   logic             deq_fire;

   // Admission depends only on registered occupancy, so upstream sees no
   // combinational path from decode back-pressure.
   assign in_ready  = (count <= ENQ_LIMIT);
   assign out_valid = (count != '0);
   assign out_num   = (count < DEC_N) ? count : DEC_N;
   assign enq_fire  = in_valid && in_ready && !flush && !rst;
   assign deq_fire  = out_valid && out_ready && !flush;

   // Each valid slot lands at tail plus the number of valid slots below it.
   always_comb begin
      // NOTE: blocking assignments here build a running prefix sum; each loop
      // iteration must see the value updated by the previous one.
      enq_num = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         slot_off[i] = enq_num;
         if (in_mask[i]) enq_num = enq_num + CNT_W'(1);
      end
   end

   always_comb begin
      out_inst = '0;
      out_pc   = '0;
      out_mask = '0;
      for (int j = 0; j < DEC_W; j++) begin
         if (CNT_W'(j) < count) begin
            out_mask[j]         = 1'b1;
            out_inst[32*j +: 32] = mem_inst[head + PTR_W'(j)];
            out_pc[32*j +: 32]   = mem_pc[head + PTR_W'(j)];
         end
      end
   end

   // NOTE: the entry array carries no reset; stale contents are never visible
   // because lanes beyond count are forced to zero.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (in_mask[i]) begin
               mem_inst[tail + PTR_W'(slot_off[i])] <= in_inst[32*i +: 32];
               mem_pc[tail + PTR_W'(slot_off[i])]   <= in_pc + 32'(4 * i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq_fire) tail <= tail + PTR_W'(enq_num);
         if (deq_fire) head <= head + PTR_W'(out_num);
         count <= count + (enq_fire ? enq_num : '0) - (deq_fire ? out_num : '0);
      end
   end

endmodule
